// File: rtl/bayer_capture_pkg.sv
// Shared types and constants for the Bayer window capture block.
package bayer_capture_pkg;

   localparam int PIX_IN_W   = 12;
   localparam int PIX_OUT_W  = 8;
   localparam int DEF_WIDTH  = 320;
   localparam int DEF_HEIGHT = 240;
   localparam int CNT_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FLOW,
      ST_WAIT_FHIGH,
      ST_ACTIVE,
      ST_DONE
   } state_t;

   // Black-level subtraction saturating at zero, then keep the top 8 bits.
   function automatic logic [PIX_OUT_W-1:0] blc_trunc(input logic [PIX_IN_W-1:0] pix,
                                                      input logic [PIX_IN_W-1:0] black);
      logic [PIX_IN_W-1:0] diff;
      diff = (pix > black) ? (pix - black) : '0;
      return diff[PIX_IN_W-1 -: PIX_OUT_W];
   endfunction

endpackage

// File: rtl/bayer_capture_if.sv
// Sensor-side inputs and demosaic-side outputs of the capture block.
interface bayer_capture_if;
   import bayer_capture_pkg::*;

   logic                 iStart;
   logic                 iFval;
   logic                 iLval;
   logic [PIX_IN_W-1:0]  iPixel;
   logic [PIX_OUT_W-1:0] oData;
   logic                 oValid;
   logic                 oNewFrame;
   logic                 oDone;
   logic                 oShortFrame;
   logic [15:0]          oFrameCnt;

   modport master (
      output iStart, iFval, iLval, iPixel,
      input  oData, oValid, oNewFrame, oDone, oShortFrame, oFrameCnt
   );

   modport slave (
      input  iStart, iFval, iLval, iPixel,
      output oData, oValid, oNewFrame, oDone, oShortFrame, oFrameCnt
   );

endinterface

// File: rtl/bayer_crop_counter.sv
// Column/row position counters for the active frame and the crop-window hit test.
module bayer_crop_counter
   import bayer_capture_pkg::*;
#(
   parameter int width   = DEF_WIDTH,
   parameter int height  = DEF_HEIGHT,
   parameter int xOffset = 0,
   parameter int yOffset = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_run,
   input  logic i_lval,
   output logic o_hit
);

   localparam logic [CNT_W-1:0] X_LO = CNT_W'(xOffset);
   localparam logic [CNT_W-1:0] Y_LO = CNT_W'(yOffset);
   localparam logic [CNT_W-1:0] X_N  = CNT_W'(width);
   localparam logic [CNT_W-1:0] Y_N  = CNT_W'(height);

   logic [CNT_W-1:0] r_col;
   logic [CNT_W-1:0] r_row;
   logic             r_lval_d;
   logic [CNT_W-1:0] w_col_rel;
   logic [CNT_W-1:0] w_row_rel;

   always_ff @(posedge clk) begin
      if (reset || !i_run) begin
         r_col    <= '0;
         r_row    <= '0;
         r_lval_d <= 1'b0;
      end else begin
         r_lval_d <= i_lval;
         if (i_lval) begin
            if (r_col != '1) r_col <= r_col + 1'b1;
         end else if (r_lval_d) begin
            r_col <= '0;
            if (r_row != '1) r_row <= r_row + 1'b1;
         end
      end
   end

   // Positions left of/above the origin wrap to large values and fail the compare.
   assign w_col_rel = r_col - X_LO;
   assign w_row_rel = r_row - Y_LO;
   assign o_hit     = i_run & i_lval & (w_col_rel < X_N) & (w_row_rel < Y_N);

endmodule

// File: rtl/bayer_capture.sv
// Single-frame Bayer window capture; define BAYER_CAPTURE_BLC_EN for black-level
// subtraction (adds one cycle of latency to oData/oValid/oDone).
//
// state         | meaning
// ST_IDLE       | waiting for iStart
// ST_WAIT_FLOW  | armed mid-frame, waiting for iFval to drop
// ST_WAIT_FHIGH | armed, waiting for the next iFval rise
// ST_ACTIVE     | frame in progress, emitting in-window samples
// ST_DONE       | window complete, one cycle to re-arm
module bayer_capture
   import bayer_capture_pkg::*;
#(
   parameter int width      = DEF_WIDTH,
   parameter int height     = DEF_HEIGHT,
   parameter int xOffset    = 0,
   parameter int yOffset    = 0,
   parameter int blackLevel = 16
) (
   input  logic            clk,
   input  logic            reset,
   bayer_capture_if.slave  bus
);

`ifdef BAYER_CAPTURE_BLC_EN
   localparam int LAT    = 2;
   localparam bit BLC_ON = 1'b1;
`else
   localparam int LAT    = 1;
   localparam bit BLC_ON = 1'b0;
`endif

   localparam logic [PIX_IN_W-1:0] BLACK    = BLC_ON ? PIX_IN_W'(blackLevel) : '0;
   localparam logic [31:0]         LAST_IDX = 32'(width * height - 1);

   state_t               r_state;
   state_t               w_next;
   logic                 w_new;
   logic                 w_evt_done;
   logic                 w_evt_short;
   logic                 w_hit;
   logic                 w_last;
   logic [31:0]          r_acc;
   logic                 r_new;
   logic                 r_valid;
   logic [PIX_OUT_W-1:0] r_data;
   logic [LAT:0]         r_done_sr;
   logic [LAT:0]         r_short_sr;
   logic [15:0]          r_frame_cnt;

   bayer_crop_counter #(
      .width   (width),
      .height  (height),
      .xOffset (xOffset),
      .yOffset (yOffset)
   ) u_crop (
      .clk    (clk),
      .reset  (reset),
      .i_run  (r_state == ST_ACTIVE),
      .i_lval (bus.iFval & bus.iLval),
      .o_hit  (w_hit)
   );

   assign w_last = w_hit && (r_acc == LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_new       = 1'b0;
      w_evt_done  = 1'b0;
      w_evt_short = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.iStart) w_next = bus.iFval ? ST_WAIT_FLOW : ST_WAIT_FHIGH;
            else            w_next = ST_IDLE;
         end
         ST_WAIT_FLOW: begin
            if (!bus.iFval) w_next = ST_WAIT_FHIGH;
         end
         ST_WAIT_FHIGH: begin
            if (bus.iFval) begin
               w_next = ST_ACTIVE;
               w_new  = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!bus.iFval) begin
               w_next      = ST_IDLE;
               w_evt_done  = 1'b1;
               w_evt_short = 1'b1;
            end else if (w_last) begin
               w_next     = ST_DONE;
               w_evt_done = 1'b1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || r_state != ST_ACTIVE) r_acc <= '0;
      else if (w_hit)                    r_acc <= r_acc + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) r_new <= 1'b0;
      else       r_new <= w_new;
   end

`ifdef BAYER_CAPTURE_BLC_EN
   logic                r_hit_d;
   logic [PIX_IN_W-1:0] r_pix_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit_d <= 1'b0;
         r_pix_d <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_hit_d <= w_hit;
         if (w_hit) r_pix_d <= bus.iPixel;
         r_valid <= r_hit_d;
         if (r_hit_d) r_data <= blc_trunc(r_pix_d, BLACK);
      end
   end
`else
   // BLACK is zero here, so blc_trunc reduces to iPixel[11:4].
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= w_hit;
         if (w_hit) r_data <= blc_trunc(bus.iPixel, BLACK);
      end
   end
`endif

   // End-of-window events trail the data path by one cycle so oDone follows the last oValid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done_sr   <= '0;
         r_short_sr  <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_done_sr  <= {r_done_sr[LAT-1:0], w_evt_done};
         r_short_sr <= {r_short_sr[LAT-1:0], w_evt_short};
         if (r_done_sr[LAT-1] && !r_short_sr[LAT-1]) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign bus.oData       = r_data;
   assign bus.oValid      = r_valid;
   assign bus.oNewFrame   = r_new;
   assign bus.oDone       = r_done_sr[LAT];
   assign bus.oShortFrame = r_short_sr[LAT];
   assign bus.oFrameCnt   = r_frame_cnt;

endmodule

// File: tb/tb_bayer_capture.sv
// Self-checking bench for bayer_capture: 8x4 window at (2,1) on ~10x6 sensor frames.
module tb_bayer_capture;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int XO = 2;
   localparam int YO = 1;
   localparam int BL = 16;
`ifdef BAYER_CAPTURE_BLC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bayer_capture_if u_if();

   bayer_capture #(
      .width      (W),
      .height     (H),
      .xOffset    (XO),
      .yOffset    (YO),
      .blackLevel (BL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   int n_checks = 0;
   int n_errors = 0;
   int pcyc     = 0;

   always @(posedge clk) pcyc++;

   logic [7:0] obs_q[$];
   int nf_cnt, done_cnt, short_cnt, done_short, done_fc, done_pcyc;
   int first_v_pcyc, last_v_pcyc;

   logic [7:0]  exp_q[$];
   int          exp_fc;
   int          first_drive_pcyc;
   logic [11:0] samp_origin;
   bit          blc_dir;

   always @(negedge clk) begin
      if (!reset) begin
         if (u_if.oValid) begin
            obs_q.push_back(u_if.oData);
            if (first_v_pcyc < 0) first_v_pcyc = pcyc;
            last_v_pcyc = pcyc;
         end
         if (u_if.oNewFrame) nf_cnt++;
         if (u_if.oDone) begin
            done_cnt++;
            done_pcyc  = pcyc;
            done_short = int'(u_if.oShortFrame);
            done_fc    = int'(u_if.oFrameCnt);
         end
         if (u_if.oShortFrame) short_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: clamp (pixel - black) at zero when BLC is built in, then divide by 16.
   function automatic logic [7:0] model_out(input logic [11:0] p);
      int v;
      v = int'(p);
`ifdef BAYER_CAPTURE_BLC_EN
      v = v - BL;
      if (v < 0) v = 0;
`endif
      return 8'(v / 16);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      obs_q.delete();
      exp_q.delete();
      nf_cnt = 0; done_cnt = 0; short_cnt = 0; done_short = 0; done_fc = -1;
      done_pcyc = -1; first_v_pcyc = -1; last_v_pcyc = -1; first_drive_pcyc = -1;
   endtask

   task automatic pulse_start();
      u_if.iStart = 1'b1;
      tick();
      u_if.iStart = 1'b0;
   endtask

   task automatic send_frame(input int rows, input int cols, input bit capture, input int start_row);
      logic [11:0] px;
      u_if.iFval = 1'b1;
      u_if.iLval = 1'b0;
      tick(); tick();
      for (int r = 0; r < rows; r++) begin
         if (r == start_row) pulse_start();
         for (int c = 0; c < cols; c++) begin
            if (blc_dir && r == YO && c == XO)          px = 12'h00A;
            else if (blc_dir && r == YO && c == XO + 1) px = 12'h110;
            else                                        px = 12'($urandom_range(0, 4095));
            if (r == YO && c == XO) samp_origin = px;
            if (capture && c >= XO && c < XO + W && r >= YO && r < YO + H) begin
               if (exp_q.size() == 0) first_drive_pcyc = pcyc;
               exp_q.push_back(model_out(px));
            end
            u_if.iLval  = 1'b1;
            u_if.iPixel = px;
            tick();
         end
         u_if.iLval  = 1'b0;
         u_if.iPixel = 12'($urandom_range(0, 4095));
         tick(); tick();
      end
      u_if.iFval = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic finish_frame(input string tag, input bit captured, input bit exp_short);
      int n;
      repeat (4) tick();
      check_eq({tag, "_nvalid"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check_eq({tag, "_data"}, 32'(obs_q[i]), 32'(exp_q[i]));
      if (captured) begin
         check_eq({tag, "_newframe"}, 32'(nf_cnt), 32'd1);
         check_eq({tag, "_done"}, 32'(done_cnt), 32'd1);
         check_eq({tag, "_short"}, 32'(short_cnt), 32'(exp_short));
         check_eq({tag, "_done_short"}, 32'(done_short), 32'(exp_short));
         check_eq({tag, "_fcnt_at_done"}, 32'(done_fc), 32'(exp_fc & 16'hFFFF));
         check_eq({tag, "_fcnt"}, 32'(u_if.oFrameCnt), 32'(exp_fc & 16'hFFFF));
         if (!exp_short) check_eq({tag, "_done_lat"}, 32'(done_pcyc), 32'(last_v_pcyc + 1));
         if (exp_q.size() > 0)
            check_eq({tag, "_latency"}, 32'(first_v_pcyc), 32'(first_drive_pcyc + LAT));
      end else begin
         check_eq({tag, "_newframe"}, 32'(nf_cnt), 32'd0);
         check_eq({tag, "_done"}, 32'(done_cnt), 32'd0);
      end
      clear_mon();
   endtask

   initial begin
      int rows, cols;
      bit sh;
      reset       = 1'b1;
      u_if.iStart = 1'b0;
      u_if.iFval  = 1'b0;
      u_if.iLval  = 1'b0;
      u_if.iPixel = '0;
      blc_dir     = 1'b0;
      exp_fc      = 0;
      samp_origin = '0;
      clear_mon();
      repeat (3) tick();
      check_eq("rst_data",  32'(u_if.oData), 32'd0);
      check_eq("rst_valid", 32'(u_if.oValid), 32'd0);
      check_eq("rst_nf",    32'(u_if.oNewFrame), 32'd0);
      check_eq("rst_done",  32'(u_if.oDone), 32'd0);
      check_eq("rst_short", 32'(u_if.oShortFrame), 32'd0);
      check_eq("rst_fcnt",  32'(u_if.oFrameCnt), 32'd0);
      reset = 1'b0;
      tick();

      // Full capture, with stray iLval while iFval is low beforehand.
      pulse_start();
      u_if.iLval = 1'b1;
      repeat (3) tick();
      u_if.iLval = 1'b0;
      tick();
      send_frame(6, 10, 1'b1, -1);
      exp_fc++;
      if (obs_q.size() > 0) check_eq("origin_px", 32'(obs_q[0]), 32'(model_out(samp_origin)));
      else                  check_eq("origin_px_missing", 32'(obs_q.size()), 32'd1);
      finish_frame("full", 1'b1, 1'b0);

      // Arm mid-frame: that frame is skipped, the next one is captured.
      send_frame(6, 10, 1'b0, 2);
      finish_frame("midarm", 1'b0, 1'b0);
      send_frame(6, 10, 1'b1, -1);
      exp_fc++;
      finish_frame("after_midarm", 1'b1, 1'b0);

      // Short frame: only window rows 1 and 2 arrive.
      pulse_start();
      send_frame(3, 10, 1'b1, -1);
      finish_frame("short", 1'b1, 1'b1);

      // Randomised sensor geometry; rows below 5 leave the window incomplete.
      for (int k = 0; k < 5; k++) begin
         rows = $urandom_range(3, 8);
         cols = $urandom_range(10, 12);
         sh   = (rows < YO + H);
         pulse_start();
         send_frame(rows, cols, 1'b1, -1);
         if (!sh) exp_fc++;
         finish_frame("rand", 1'b1, sh);
      end

`ifdef BAYER_CAPTURE_BLC_EN
      blc_dir = 1'b1;
      pulse_start();
      send_frame(6, 10, 1'b1, -1);
      exp_fc++;
      if (obs_q.size() > 1) begin
         check_eq("blc_under", 32'(obs_q[0]), 32'h00);
         check_eq("blc_over",  32'(obs_q[1]), 32'h10);
      end else begin
         check_eq("blc_missing", 32'(obs_q.size()), 32'd2);
      end
      finish_frame("blc", 1'b1, 1'b0);
      blc_dir = 1'b0;
`endif

      // Reset in the middle of window row 1, then reset together with iStart.
      pulse_start();
      u_if.iFval = 1'b1;
      tick(); tick();
      for (int c = 0; c < 10; c++) begin
         u_if.iLval  = 1'b1;
         u_if.iPixel = 12'($urandom_range(0, 4095));
         tick();
      end
      u_if.iLval = 1'b0;
      tick(); tick();
      for (int c = 0; c < 5; c++) begin
         u_if.iLval  = 1'b1;
         u_if.iPixel = 12'($urandom_range(0, 4095));
         tick();
      end
      reset = 1'b1;
      tick();
      check_eq("midrst_valid", 32'(u_if.oValid), 32'd0);
      check_eq("midrst_data",  32'(u_if.oData), 32'd0);
      check_eq("midrst_done",  32'(u_if.oDone), 32'd0);
      check_eq("midrst_fcnt",  32'(u_if.oFrameCnt), 32'd0);
      exp_fc = 0;
      u_if.iStart = 1'b1;
      tick();
      reset       = 1'b0;
      u_if.iStart = 1'b0;
      clear_mon();
      repeat (3) tick();
      u_if.iLval = 1'b0;
      u_if.iFval = 1'b0;
      tick(); tick();
      send_frame(6, 10, 1'b0, -1);
      finish_frame("rst_vs_start", 1'b0, 1'b0);

      pulse_start();
      send_frame(6, 10, 1'b1, -1);
      exp_fc++;
      finish_frame("post_rst", 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
